// File: rtl/vx_stream_pkg.sv
// vx_stream_pkg: shared sizing helpers and output-stage mode constants for the stream arbiter switch
package vx_stream_pkg;
  localparam int BUF_PASS = 0;
  localparam int BUF_SKID = 1;
  localparam int BUF_REG  = 2;
  localparam int PERF_W   = 32;
  function automatic int up_div(input int n, input int d);
    return (n + d - 1) / d;
  endfunction
  function automatic int log2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic int beat_width(input int sel_w, input int data_w);
    return 1 + sel_w + data_w;
  endfunction
endpackage

// File: rtl/vx_stream_rr_lock_arb.sv
// vx_stream_rr_lock_arb: per-group round-robin arbiter that holds its grant from first beat to last beat
module vx_stream_rr_lock_arb #(
  parameter int NUM_REQS     = 4,
  parameter int LOG_NUM_REQS = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQS-1:0]     valid,
  input  logic                    last,
  input  logic                    fire,
  output logic [LOG_NUM_REQS-1:0] grant,
  output logic                    grant_valid
);
  logic [LOG_NUM_REQS-1:0] rr_ptr_q, rr_ptr_d, grant_q, grant_d, pick;
  logic locked_q, locked_d, found, held;
  // first valid slot at or after rr_ptr, then wrap to the low slots; held tracks the locked slot's valid
  always_comb begin
    found = 1'b0;
    pick  = grant_q;
    held  = 1'b0;
    for (int k = 0; k < NUM_REQS; k++)
      if (!found && valid[k] && k >= int'(rr_ptr_q)) begin
        found = 1'b1;
        pick  = LOG_NUM_REQS'(k);
      end
    for (int k = 0; k < NUM_REQS; k++)
      if (!found && valid[k]) begin
        found = 1'b1;
        pick  = LOG_NUM_REQS'(k);
      end
    for (int k = 0; k < NUM_REQS; k++)
      if (grant_q == LOG_NUM_REQS'(k)) held = valid[k];
    grant       = locked_q ? grant_q : pick;
    grant_valid = locked_q ? held : found;
  end
  // lock on a non-final beat; on the final beat release and move the pointer past the winner
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    locked_d = locked_q;
    grant_d  = grant_q;
    if (fire) begin
      locked_d = ~last;
      grant_d  = grant;
      if (last) rr_ptr_d = (grant == LOG_NUM_REQS'(NUM_REQS - 1)) ? '0 : grant + 1'b1;
    end
  end
  // arbiter state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_q <= '0;
      locked_q <= 1'b0;
      grant_q  <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      locked_q <= locked_d;
      grant_q  <= grant_d;
    end
  end
endmodule

// File: rtl/vx_stream_arb_switch.sv
// vx_stream_arb_switch: N-to-M packet-aware stream concentrator; define VX_STREAM_ARB_SWITCH_PERF_EN for per-output stall counters
module vx_stream_arb_switch
  import vx_stream_pkg::*;
#(
  parameter int NUM_INPUTS  = 4,
  parameter int NUM_OUTPUTS = 1,
  parameter int NUM_LANES   = 1,
  parameter int DATAW       = 1,
  parameter int BUFFERED    = 0,
  localparam int NUM_REQS     = up_div(NUM_INPUTS, NUM_OUTPUTS),
  localparam int LOG_NUM_REQS = log2_min1(NUM_REQS)
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [NUM_INPUTS-1:0]                 valid_in,
  input  logic [NUM_INPUTS*NUM_LANES*DATAW-1:0] data_in,
  input  logic [NUM_INPUTS-1:0]                 last_in,
  output logic [NUM_INPUTS-1:0]                 ready_in,
  output logic [NUM_OUTPUTS-1:0]                valid_out,
  output logic [NUM_OUTPUTS*NUM_LANES*DATAW-1:0] data_out,
  output logic [NUM_OUTPUTS-1:0]                last_out,
  output logic [NUM_OUTPUTS*LOG_NUM_REQS-1:0]   sel_out,
  input  logic [NUM_OUTPUTS-1:0]                ready_out
`ifdef VX_STREAM_ARB_SWITCH_PERF_EN
  ,
  output logic [NUM_OUTPUTS*PERF_W-1:0]         perf_stalls
`endif
);
  localparam int BW = NUM_LANES * DATAW;
  typedef struct packed {
    logic                    last;
    logic [LOG_NUM_REQS-1:0] sel;
    logic [BW-1:0]           data;
  } beat_t;
  if ($bits(beat_t) != beat_width(LOG_NUM_REQS, BW)) begin : g_bad_beat
    $error("vx_stream_arb_switch: beat layout mismatch");
  end
  if (NUM_OUTPUTS > NUM_INPUTS) begin : g_bad_outputs
    $error("vx_stream_arb_switch: NUM_OUTPUTS must not exceed NUM_INPUTS");
  end
  if (BUFFERED < BUF_PASS || BUFFERED > BUF_REG) begin : g_bad_buffered
    $error("vx_stream_arb_switch: BUFFERED must be 0, 1 or 2");
  end
  for (genvar o = 0; o < NUM_OUTPUTS; o++) begin : g_out
    logic [NUM_REQS-1:0]     gv, gl;
    logic [BW-1:0]           gd [NUM_REQS];
    logic [LOG_NUM_REQS-1:0] grant;
    logic                    grant_valid, stage_ready, fire, out_valid;
    beat_t                   in_beat, out_beat;
    for (genvar r = 0; r < NUM_REQS; r++) begin : g_slot
      if (o * NUM_REQS + r < NUM_INPUTS) begin : g_live
        assign gv[r] = valid_in[o*NUM_REQS+r];
        assign gl[r] = last_in[o*NUM_REQS+r];
        assign gd[r] = data_in[(o*NUM_REQS+r)*BW +: BW];
        assign ready_in[o*NUM_REQS+r] = stage_ready & grant_valid & (grant == LOG_NUM_REQS'(r));
      end else begin : g_missing
        assign gv[r] = 1'b0;
        assign gl[r] = 1'b0;
        assign gd[r] = '0;
      end
    end
    // steer the granted slot's payload into the output stage, tagged with its local index
    always_comb begin
      in_beat = '{last: 1'b0, sel: grant, data: '0};
      for (int k = 0; k < NUM_REQS; k++)
        if (grant == LOG_NUM_REQS'(k)) begin
          in_beat.last = gl[k];
          in_beat.data = gd[k];
        end
    end
    assign fire = grant_valid & stage_ready;
    vx_stream_rr_lock_arb #(
      .NUM_REQS    (NUM_REQS),
      .LOG_NUM_REQS(LOG_NUM_REQS)
    ) u_arb (
      .clk        (clk),
      .reset      (reset),
      .valid      (gv),
      .last       (in_beat.last),
      .fire       (fire),
      .grant      (grant),
      .grant_valid(grant_valid)
    );
    if (BUFFERED == BUF_PASS) begin : g_pass
      assign stage_ready = ready_out[o];
      assign out_valid   = grant_valid & ~reset;
      assign out_beat    = reset ? '0 : in_beat;
    end else begin : g_skid
      logic  out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
      beat_t out_beat_q, out_beat_d, skid_beat_q, skid_beat_d;
      assign stage_ready = ~skid_valid_q;
      assign out_valid   = out_valid_q;
      assign out_beat    = out_beat_q;
      // the skid register already registers both valid and ready, so modes 1 and 2 share it;
      // the output slot refills from skid first, and the skid only catches a beat while the output is stalled
      always_comb begin
        out_valid_d  = out_valid_q;
        out_beat_d   = out_beat_q;
        skid_valid_d = skid_valid_q;
        skid_beat_d  = skid_beat_q;
        if (!out_valid_q || ready_out[o]) begin
          out_valid_d  = skid_valid_q | fire;
          out_beat_d   = skid_valid_q ? skid_beat_q : fire ? in_beat : out_beat_q;
          skid_valid_d = 1'b0;
        end else if (fire) begin
          skid_valid_d = 1'b1;
          skid_beat_d  = in_beat;
        end
      end
      // output and skid registers; reset discards any buffered beats
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          out_valid_q  <= 1'b0;
          out_beat_q   <= '0;
          skid_valid_q <= 1'b0;
          skid_beat_q  <= '0;
        end else begin
          out_valid_q  <= out_valid_d;
          out_beat_q   <= out_beat_d;
          skid_valid_q <= skid_valid_d;
          skid_beat_q  <= skid_beat_d;
        end
      end
    end
    assign valid_out[o]                           = out_valid;
    assign data_out[o*BW +: BW]                   = out_beat.data;
    assign last_out[o]                            = out_beat.last;
    assign sel_out[o*LOG_NUM_REQS +: LOG_NUM_REQS] = out_beat.sel;
`ifdef VX_STREAM_ARB_SWITCH_PERF_EN
    logic [PERF_W-1:0] stalls_q, stalls_d;
    // count cycles a beat is presented but held off downstream
    always_comb stalls_d = stalls_q + PERF_W'(out_valid & ~ready_out[o]);
    // stall counter register
    always_ff @(posedge clk or posedge reset) begin
      if (reset) stalls_q <= '0;
      else stalls_q <= stalls_d;
    end
    assign perf_stalls[o*PERF_W +: PERF_W] = stalls_q;
`endif
  end
endmodule

// File: tb/tb_vx_stream_arb_switch.sv
// tb_vx_stream_arb_switch: directed checks of arbitration, packet lock, buffering and reset
module tb_vx_stream_arb_switch;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  int vecs = 0;
  int errs = 0;

  logic [3:0]  a_vin = '0, a_lin = '0, a_rin;
  logic [31:0] a_din = '0;
  logic        a_vout, a_lout, a_rout = 1'b1;
  logic [7:0]  a_dout;
  logic [1:0]  a_sel;

  logic [3:0]  b_vin = '0, b_lin = '0, b_rin;
  logic [31:0] b_din = '0;
  logic        b_vout, b_lout, b_rout = 1'b1;
  logic [7:0]  b_dout;
  logic [1:0]  b_sel;

  logic [4:0]  c_vin = '0, c_lin = '0, c_rin;
  logic [39:0] c_din = '0;
  logic [1:0]  c_vout, c_lout, c_rout = 2'b11;
  logic [15:0] c_dout;
  logic [3:0]  c_sel;

`ifdef VX_STREAM_ARB_SWITCH_PERF_EN
  logic [31:0] a_perf, b_perf;
  logic [63:0] c_perf;
`endif

  vx_stream_arb_switch #(.NUM_INPUTS(4), .NUM_OUTPUTS(1), .NUM_LANES(1), .DATAW(8), .BUFFERED(0)) dut_a (
    .clk(clk), .reset(reset), .valid_in(a_vin), .data_in(a_din), .last_in(a_lin), .ready_in(a_rin),
    .valid_out(a_vout), .data_out(a_dout), .last_out(a_lout), .sel_out(a_sel), .ready_out(a_rout)
`ifdef VX_STREAM_ARB_SWITCH_PERF_EN
    , .perf_stalls(a_perf)
`endif
  );

  vx_stream_arb_switch #(.NUM_INPUTS(4), .NUM_OUTPUTS(1), .NUM_LANES(1), .DATAW(8), .BUFFERED(1)) dut_b (
    .clk(clk), .reset(reset), .valid_in(b_vin), .data_in(b_din), .last_in(b_lin), .ready_in(b_rin),
    .valid_out(b_vout), .data_out(b_dout), .last_out(b_lout), .sel_out(b_sel), .ready_out(b_rout)
`ifdef VX_STREAM_ARB_SWITCH_PERF_EN
    , .perf_stalls(b_perf)
`endif
  );

  vx_stream_arb_switch #(.NUM_INPUTS(5), .NUM_OUTPUTS(2), .NUM_LANES(1), .DATAW(8), .BUFFERED(0)) dut_c (
    .clk(clk), .reset(reset), .valid_in(c_vin), .data_in(c_din), .last_in(c_lin), .ready_in(c_rin),
    .valid_out(c_vout), .data_out(c_dout), .last_out(c_lout), .sel_out(c_sel), .ready_out(c_rout)
`ifdef VX_STREAM_ARB_SWITCH_PERF_EN
    , .perf_stalls(c_perf)
`endif
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    @(negedge clk);
    vecs++;
    if (a_vout !== 1'b0 || a_lout !== 1'b0 || a_sel !== 2'd0) begin
      errs++;
      $display("FAIL reset_a: valid=%b last=%b sel=%0d, want 0 0 0", a_vout, a_lout, a_sel);
    end
    vecs++;
    if (b_vout !== 1'b0 || b_lout !== 1'b0 || b_sel !== 2'd0) begin
      errs++;
      $display("FAIL reset_b: valid=%b last=%b sel=%0d, want 0 0 0", b_vout, b_lout, b_sel);
    end
    vecs++;
    if (c_vout !== 2'b00 || c_lout !== 2'b00 || c_sel !== 4'd0) begin
      errs++;
      $display("FAIL reset_c: valid=%b last=%b sel=%h, want 00 00 0", c_vout, c_lout, c_sel);
    end
    a_vin = 4'hF;
    a_lin = 4'hF;
    #1;
    vecs++;
    if (a_vout !== 1'b0) begin
      errs++;
      $display("FAIL reset_gate_a: valid=%b, want 0 while reset held", a_vout);
    end
    a_vin = '0;
    a_lin = '0;
    #1 reset = 1'b0;
    step;
  endtask

  task automatic test_fairness;
    logic [1:0] e;
    a_vin = 4'hF;
    a_lin = 4'hF;
    a_din = {8'h13, 8'h12, 8'h11, 8'h10};
    for (int k = 0; k < 5; k++) begin
      e = 2'(k % 4);
      @(negedge clk);
      vecs++;
      if (a_vout !== 1'b1 || a_sel !== e || a_dout !== 8'h10 + 8'(e) || a_rin !== 4'b0001 << e) begin
        errs++;
        $display("FAIL fair[%0d]: valid=%b sel=%0d data=%h rdy=%b, want 1 %0d %h %b",
                 k, a_vout, a_sel, a_dout, a_rin, e, 8'h10 + 8'(e), 4'b0001 << e);
      end
      step;
    end
    a_vin = '0;
  endtask

  task automatic test_packet_lock;
    a_vin = 4'b0010;
    a_lin = 4'b0010;
    a_din[15:8] = 8'h21;
    @(negedge clk);
    vecs++;
    if (a_vout !== 1'b1 || a_sel !== 2'd1 || a_dout !== 8'h21) begin
      errs++;
      $display("FAIL lock_pre: valid=%b sel=%0d data=%h, want 1 1 21", a_vout, a_sel, a_dout);
    end
    step;
    a_vin = 4'hF;
    for (int b = 0; b < 3; b++) begin
      a_lin = (b == 2) ? 4'b1111 : 4'b1011;
      a_din[23:16] = 8'hA0 + 8'(b);
      @(negedge clk);
      vecs++;
      if (a_vout !== 1'b1 || a_sel !== 2'd2 || a_dout !== 8'hA0 + 8'(b) || a_lout !== (b == 2) || a_rin !== 4'b0100) begin
        errs++;
        $display("FAIL lock_beat[%0d]: valid=%b sel=%0d data=%h last=%b rdy=%b, want 1 2 %h %b 0100",
                 b, a_vout, a_sel, a_dout, a_lout, a_rin, 8'hA0 + 8'(b), b == 2);
      end
      step;
    end
    @(negedge clk);
    vecs++;
    if (a_vout !== 1'b1 || a_sel !== 2'd3 || a_rin !== 4'b1000) begin
      errs++;
      $display("FAIL lock_next: valid=%b sel=%0d rdy=%b, want 1 3 1000", a_vout, a_sel, a_rin);
    end
    step;
    a_vin = '0;
  endtask

  task automatic test_bubble;
    a_vin = 4'b0010;
    a_lin = 4'b0000;
    a_din[15:8] = 8'hB0;
    @(negedge clk);
    vecs++;
    if (a_vout !== 1'b1 || a_sel !== 2'd1 || a_dout !== 8'hB0 || a_lout !== 1'b0) begin
      errs++;
      $display("FAIL bubble_first: valid=%b sel=%0d data=%h last=%b, want 1 1 b0 0", a_vout, a_sel, a_dout, a_lout);
    end
    step;
    a_vin = 4'b0001;
    a_lin = 4'b0001;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      vecs++;
      if (a_vout !== 1'b0 || a_rin[0] !== 1'b0) begin
        errs++;
        $display("FAIL bubble_gap[%0d]: valid=%b rdy0=%b, want 0 0", k, a_vout, a_rin[0]);
      end
      step;
    end
    a_vin = 4'b0011;
    a_lin = 4'b0011;
    a_din[15:8] = 8'hB1;
    @(negedge clk);
    vecs++;
    if (a_vout !== 1'b1 || a_sel !== 2'd1 || a_dout !== 8'hB1 || a_lout !== 1'b1 || a_rin !== 4'b0010) begin
      errs++;
      $display("FAIL bubble_resume: valid=%b sel=%0d data=%h last=%b rdy=%b, want 1 1 b1 1 0010",
               a_vout, a_sel, a_dout, a_lout, a_rin);
    end
    step;
    @(negedge clk);
    vecs++;
    if (a_vout !== 1'b1 || a_sel !== 2'd0) begin
      errs++;
      $display("FAIL bubble_after: valid=%b sel=%0d, want 1 0", a_vout, a_sel);
    end
    step;
    a_vin = '0;
  endtask

  task automatic test_backpressure;
    b_vin = 4'hF;
    b_lin = 4'hF;
    b_din = {8'h53, 8'h52, 8'h51, 8'h50};
    b_rout = 1'b1;
    @(negedge clk);
    vecs++;
    if (b_vout !== 1'b0 || b_rin !== 4'b0001) begin
      errs++;
      $display("FAIL bp_fill: valid=%b rdy=%b, want 0 0001", b_vout, b_rin);
    end
    step;
    b_rout = 1'b0;
    @(negedge clk);
    vecs++;
    if (b_vout !== 1'b1 || b_dout !== 8'h50 || b_sel !== 2'd0 || b_rin !== 4'b0010) begin
      errs++;
      $display("FAIL bp_skid: valid=%b data=%h sel=%0d rdy=%b, want 1 50 0 0010", b_vout, b_dout, b_sel, b_rin);
    end
    step;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      vecs++;
      if (b_vout !== 1'b1 || b_dout !== 8'h50 || b_rin !== 4'b0000) begin
        errs++;
        $display("FAIL bp_full[%0d]: valid=%b data=%h rdy=%b, want 1 50 0000", k, b_vout, b_dout, b_rin);
      end
      step;
    end
    b_rout = 1'b1;
    @(negedge clk);
    vecs++;
    if (b_vout !== 1'b1 || b_dout !== 8'h50 || b_sel !== 2'd0 || b_rin !== 4'b0000) begin
      errs++;
      $display("FAIL bp_drain0: valid=%b data=%h sel=%0d rdy=%b, want 1 50 0 0000", b_vout, b_dout, b_sel, b_rin);
    end
`ifdef VX_STREAM_ARB_SWITCH_PERF_EN
    vecs++;
    if (b_perf !== 32'd5) begin
      errs++;
      $display("FAIL bp_perf: stalls=%0d, want 5", b_perf);
    end
`endif
    step;
    @(negedge clk);
    vecs++;
    if (b_vout !== 1'b1 || b_dout !== 8'h51 || b_sel !== 2'd1 || b_rin !== 4'b0100) begin
      errs++;
      $display("FAIL bp_drain1: valid=%b data=%h sel=%0d rdy=%b, want 1 51 1 0100", b_vout, b_dout, b_sel, b_rin);
    end
    step;
    @(negedge clk);
    vecs++;
    if (b_vout !== 1'b1 || b_dout !== 8'h52 || b_sel !== 2'd2 || b_rin !== 4'b1000) begin
      errs++;
      $display("FAIL bp_drain2: valid=%b data=%h sel=%0d rdy=%b, want 1 52 2 1000", b_vout, b_dout, b_sel, b_rin);
    end
    step;
    b_vin = '0;
    @(negedge clk);
    vecs++;
    if (b_vout !== 1'b1 || b_dout !== 8'h53 || b_sel !== 2'd3) begin
      errs++;
      $display("FAIL bp_drain3: valid=%b data=%h sel=%0d, want 1 53 3", b_vout, b_dout, b_sel);
    end
    step;
    @(negedge clk);
    vecs++;
    if (b_vout !== 1'b0) begin
      errs++;
      $display("FAIL bp_empty: valid=%b, want 0", b_vout);
    end
`ifdef VX_STREAM_ARB_SWITCH_PERF_EN
    vecs++;
    if (b_perf !== 32'd5) begin
      errs++;
      $display("FAIL bp_perf_hold: stalls=%0d, want 5", b_perf);
    end
`endif
    step;
  endtask

  task automatic test_short_group;
    c_din = {8'hC4, 8'hC3, 8'hC2, 8'hC1, 8'hC0};
    c_lin = 5'h1F;
    c_vin = 5'b10000;
    @(negedge clk);
    vecs++;
    if (c_vout !== 2'b10 || c_sel[3:2] !== 2'd1 || c_dout[15:8] !== 8'hC4 || c_rin !== 5'b10000) begin
      errs++;
      $display("FAIL short_solo: valid=%b sel=%h data=%h rdy=%b, want 10 sel1=1 c4 10000", c_vout, c_sel, c_dout, c_rin);
    end
    step;
    c_vin = 5'b11000;
    @(negedge clk);
    vecs++;
    if (c_vout !== 2'b10 || c_sel[3:2] !== 2'd0 || c_dout[15:8] !== 8'hC3 || c_rin !== 5'b01000) begin
      errs++;
      $display("FAIL short_wrap: valid=%b sel=%h data=%h rdy=%b, want 10 sel1=0 c3 01000", c_vout, c_sel, c_dout, c_rin);
    end
    step;
    c_vin = 5'b11001;
    @(negedge clk);
    vecs++;
    if (c_vout !== 2'b11 || c_sel !== 4'b0100 || c_dout !== 16'hC4C0 || c_rin !== 5'b10001) begin
      errs++;
      $display("FAIL short_both: valid=%b sel=%h data=%h rdy=%b, want 11 4 c4c0 10001", c_vout, c_sel, c_dout, c_rin);
    end
    step;
    c_vin = '0;
  endtask

  task automatic test_reset_midpacket;
    a_vin = 4'b0010;
    a_lin = 4'b0000;
    a_din[15:8] = 8'hD0;
    @(negedge clk);
    vecs++;
    if (a_vout !== 1'b1 || a_sel !== 2'd1 || a_dout !== 8'hD0) begin
      errs++;
      $display("FAIL rst_beat1: valid=%b sel=%0d data=%h, want 1 1 d0", a_vout, a_sel, a_dout);
    end
    step;
    a_din[15:8] = 8'hD1;
    #1;
    vecs++;
    if (a_vout !== 1'b1 || a_dout !== 8'hD1) begin
      errs++;
      $display("FAIL rst_beat2: valid=%b data=%h, want 1 d1", a_vout, a_dout);
    end
    reset = 1'b1;
    #1;
    vecs++;
    if (a_vout !== 1'b0) begin
      errs++;
      $display("FAIL rst_async: valid=%b, want 0", a_vout);
    end
    a_vin = 4'b0101;
    a_lin = 4'b0101;
    @(negedge clk);
    #1 reset = 1'b0;
    #1;
    vecs++;
    if (a_vout !== 1'b1 || a_sel !== 2'd0 || a_rin !== 4'b0001) begin
      errs++;
      $display("FAIL rst_regrant: valid=%b sel=%0d rdy=%b, want 1 0 0001", a_vout, a_sel, a_rin);
    end
    step;
    @(negedge clk);
    vecs++;
    if (a_vout !== 1'b1 || a_sel !== 2'd2) begin
      errs++;
      $display("FAIL rst_next: valid=%b sel=%0d, want 1 2", a_vout, a_sel);
    end
    step;
    a_vin = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, want finish before 100000");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_fairness;
    test_packet_lock;
    test_bubble;
    test_backpressure;
    test_short_group;
    test_reset_midpacket;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
